// File: rtl/stopwatch_ctrl.sv
// Centisecond stopwatch controller: debounced start/stop and clear buttons drive
// an IDLE/RUN/PAUSE/DONE machine with a prescaled, saturating binary counter.

module stopwatch_debounce #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] cnt;

  // Synchroniser, stability counter and one-cycle press pulse on a debounced rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= {DW{1'b0}};
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= {DW{1'b0}};
      end else if (cnt == DB_LAST) begin
        level <= sync2;
        cnt   <= {DW{1'b0}};
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DEBOUNCE  = 1_000_000,
  parameter int MAX_COUNT = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [13:0] count,
  output logic        running,
  output logic        done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]   MAX_VAL   = 14'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [13:0]   count_next;
  logic [13:0]   count_inc;
  logic          ss_press;
  logic          clr_press;

  stopwatch_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_ss (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_ss),
    .press (ss_press)
  );

  stopwatch_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_clr (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_clr),
    .press (clr_press)
  );

  // State, prescaler, count and decoded status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= {PW{1'b0}};
      count   <= 14'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      count   <= count_next;
      running <= (state_next == RUN);
      done    <= (state_next == DONE);
    end
  end

  // Next-state logic; a tick that lands on the saturation value beats a pause request.
  always_comb begin
    state_next = state;
    presc_next = presc;
    count_next = count;
    count_inc  = count + 14'd1;
    case (state)
      IDLE: begin
        presc_next = {PW{1'b0}};
        count_next = 14'd0;
        if (ss_press) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (presc == TICK_LAST) begin
          presc_next = {PW{1'b0}};
          if (count_inc >= MAX_VAL) begin
            count_next = MAX_VAL;
            state_next = DONE;
          end else begin
            count_next = count_inc;
            state_next = ss_press ? PAUSE : RUN;
          end
        end else begin
          presc_next = presc + PW'(1);
          state_next = ss_press ? PAUSE : RUN;
        end
      end
      PAUSE: begin
        if (ss_press) begin
          state_next = RUN;
        end else begin
          state_next = PAUSE;
        end
      end
      DONE: begin
        count_next = MAX_VAL;
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
        presc_next = {PW{1'b0}};
        count_next = 14'd0;
      end
    endcase
    if (clr_press) begin
      state_next = IDLE;
      presc_next = {PW{1'b0}};
      count_next = 14'd0;
    end else begin
      state_next = state_next;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random button
// activity, compared against an elapsed-cycles / sliding-window reference model.

module tb_stopwatch_ctrl;

  localparam int TD = 5;
  localparam int DB = 4;
  localparam int MX = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [13:0] count;
  logic        running;
  logic        done;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE(DB), .MAX_COUNT(MX)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .count   (count),
    .running (running),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Reference model: raw sample histories, debounced levels, press pulses,
  // mode (0 idle, 1 run, 2 pause, 3 done) and cycles spent running.
  bit [15:0] h_ss, h_clr;
  bit lv_ss, lv_ss_p, lv_clr, lv_clr_p;
  bit pl_ss, pl_clr;
  int mode = 0;
  int rc = 0;

  // Level accepted only if the last DB synced samples all agree.
  function automatic bit settle(bit [15:0] h, bit lv);
    for (int i = 2; i <= DB; i++) if (h[i] != h[1]) return lv;
    return h[1];
  endfunction

  function automatic logic [13:0] exp_count();
    int c = rc / TD;
    return 14'((c > MX) ? MX : c);
  endfunction

  task automatic model_edge();
    bit n_ss, n_clr;
    if (rst) begin
      h_ss = '0; h_clr = '0;
      lv_ss = 0; lv_ss_p = 0; lv_clr = 0; lv_clr_p = 0;
      pl_ss = 0; pl_clr = 0;
      mode = 0; rc = 0;
    end else begin
      if (pl_clr) begin
        mode = 0; rc = 0;
      end else begin
        case (mode)
          0: if (pl_ss) mode = 1;
          1: begin
            rc++;
            if (rc / TD >= MX) mode = 3;
            else if (pl_ss) mode = 2;
          end
          2: if (pl_ss) mode = 1;
          default: ;
        endcase
      end
      n_ss  = lv_ss && !lv_ss_p;
      n_clr = lv_clr && !lv_clr_p;
      lv_ss_p  = lv_ss;  lv_ss  = settle(h_ss, lv_ss);
      lv_clr_p = lv_clr; lv_clr = settle(h_clr, lv_clr);
      pl_ss = n_ss; pl_clr = n_clr;
      h_ss  = {h_ss[14:0], btn_ss};
      h_clr = {h_clr[14:0], btn_clr};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic press(bit ss, bit clr, int hold, int after);
    btn_ss = ss; btn_clr = clr;
    repeat (hold) tick();
    btn_ss = 0; btn_clr = 0;
    repeat (after) tick();
  endtask

  task automatic test_reset();
    rst = 1; btn_ss = 0; btn_clr = 0;
    repeat (3) tick();
    rst = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (count !== 14'd0 || running !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got count=%0d running=%b done=%b want 0/0/0", i, count, running, done);
      end
    end
  endtask

  task automatic test_start_cadence();
    btn_ss = 1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      checks++;
      if (running !== (e >= 8) || count !== 14'((e < 13) ? 0 : (e - 8) / TD)) begin
        failures++;
        $display("FAIL start_cadence edge=%0d got count=%0d running=%b want count=%0d running=%b",
                 e, count, running, (e < 13) ? 0 : (e - 8) / TD, e >= 8);
      end
    end
    press(0, 1, 6, 8);
    checks++;
    if (count !== 14'd0 || running !== 1'b0 || count !== exp_count()) begin
      failures++;
      $display("FAIL start_clear got count=%0d running=%b want 0/0", count, running);
    end
  endtask

  task automatic test_bounce();
    int n = 0;
    while (n < 40) begin
      int len = $urandom_range(1, 3);
      btn_ss = ~btn_ss;
      for (int k = 0; k < len; k++) begin
        tick(); n++;
        checks++;
        if (running !== 1'b0 || count !== 14'd0) begin
          failures++;
          $display("FAIL bounce_reject cyc=%0d got running=%b count=%0d want 0/0", n, running, count);
        end
      end
    end
    press(1, 0, 10, 10);
    checks++;
    if (running !== 1'b1 || running !== (mode == 1) || count !== exp_count()) begin
      failures++;
      $display("FAIL bounce_one_start got running=%b count=%0d want running=1 count=%0d", running, count, exp_count());
    end
    press(0, 1, 6, 8);
  endtask

  task automatic test_pause_resume();
    logic [13:0] frozen;
    press(1, 0, 6, 4);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL pr_start got running=%b want 1", running);
    end
    for (int i = 0; i < 5 && ((rc + 8) % TD) != 2; i++) tick();
    press(1, 0, 6, 2);
    frozen = exp_count();
    checks++;
    if (running !== 1'b0 || count !== frozen || (rc % TD) != 2) begin
      failures++;
      $display("FAIL pr_pause got running=%b count=%0d want running=0 count=%0d held=2", running, count, frozen);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (count !== frozen || running !== 1'b0) begin
        failures++;
        $display("FAIL pr_frozen cyc=%0d got count=%0d running=%b want %0d/0", i, count, running, frozen);
      end
    end
    press(1, 0, 6, 2);
    checks++;
    if (running !== 1'b1 || count !== frozen) begin
      failures++;
      $display("FAIL pr_resume got running=%b count=%0d want 1/%0d", running, count, frozen);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (count !== ((k == 3) ? frozen + 14'd1 : frozen)) begin
        failures++;
        $display("FAIL pr_partial k=%0d got count=%0d want %0d", k, count, (k == 3) ? frozen + 14'd1 : frozen);
      end
    end
  endtask

  task automatic test_saturation();
    bit reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      tick();
      checks++;
      if (count !== exp_count() || (count == 14'd20 && (done !== 1'b1 || running !== 1'b0))) begin
        failures++;
        $display("FAIL sat_run cyc=%0d got count=%0d running=%b done=%b want count=%0d", i, count, running, done, exp_count());
      end
      if (done === 1'b1) reached = 1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL sat_timeout got done=%b want 1 within 200 cycles", done);
    end
    press(1, 0, 6, 4);
    press(1, 0, 6, 4);
    checks++;
    if (count !== 14'd20 || done !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold got count=%0d done=%b running=%b want 20/1/0", count, done, running);
    end
    press(0, 1, 6, 4);
    checks++;
    if (count !== 14'd0 || done !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear got count=%0d done=%b running=%b want 0/0/0", count, done, running);
    end
  endtask

  task automatic test_simultaneous();
    press(1, 0, 6, 4);
    repeat (7) tick();
    press(1, 1, 6, 2);
    checks++;
    if (count !== 14'd0 || running !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL simul_both got count=%0d running=%b done=%b want 0/0/0", count, running, done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (running !== 1'b0 || count !== 14'd0) begin
        failures++;
        $display("FAIL simul_after cyc=%0d got running=%b count=%0d want 0/0", i, running, count);
      end
    end
  endtask

  task automatic test_reset_mid();
    press(1, 0, 6, 10);
    btn_ss = 1;
    repeat (4) tick();
    rst = 1;
    tick();
    checks++;
    if (count !== 14'd0 || running !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid got count=%0d running=%b done=%b want 0/0/0", count, running, done);
    end
    rst = 0; btn_ss = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (running !== 1'b0 || count !== 14'd0 || done !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_pulse cyc=%0d got running=%b count=%0d done=%b want 0/0/0", i, running, count, done);
      end
    end
  endtask

  task automatic test_random();
    int ss_left = 0;
    int clr_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (ss_left == 0) begin
        btn_ss = 1'($urandom_range(0, 1));
        ss_left = $urandom_range(1, 14);
      end
      if (clr_left == 0) begin
        btn_clr = ($urandom_range(0, 5) == 0);
        clr_left = $urandom_range(1, 14);
      end
      rst = ($urandom_range(0, 299) == 0);
      ss_left--; clr_left--;
      tick();
      checks++;
      if (count !== exp_count() || running !== (mode == 1) || done !== (mode == 3)) begin
        failures++;
        $display("FAIL random cyc=%0d got count=%0d running=%b done=%b want count=%0d running=%b done=%b",
                 i, count, running, done, exp_count(), mode == 1, mode == 3);
      end
    end
    rst = 0; btn_ss = 0; btn_clr = 0;
  endtask

  initial begin
    test_reset();
    test_start_cadence();
    test_bounce();
    test_pause_resume();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Centisecond stopwatch controller that produces the 14-bit binary value (0..9999) shown on the 4-digit seven-segment display stage. Its `count` output connects directly to the display driver's `din` input. It takes two raw, bouncing push-buttons (start/stop and clear), synchronises and debounces them, and runs a start/pause/resume/clear state machine with a saturating counter.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per count increment (0.01 s at 100 MHz); must be ≥ 2.
- `DEBOUNCE`, default 1_000_000: consecutive stable cycles required to accept a button level change; must be ≥ 2.
- `MAX_COUNT`, default 9999: saturation value; must be ≤ 16383.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_ss` in 1: raw start/stop button, asynchronous, active-high.
- `btn_clr` in 1: raw clear button, asynchronous, active-high.
- `count` out 14: current elapsed value, binary, 0..MAX_COUNT.
- `running` out 1: high while in RUN.
- `done` out 1: high while in DONE (saturated).

## Operation
- Reset values:
  - `count` = 0, `running` = 0, `done` = 0.
  - State = IDLE.
  - Prescaler = 0.
  - Synchroniser flops, debounced levels, debounce counters and press pulses all 0.
- Input path, per button, identical and independent:
  - 2-FF synchroniser, then the debouncer.
  - The debounce counter clears whenever the synced value equals the debounced level.
  - Otherwise the counter increments. On the edge where the counter equals DEBOUNCE-1 and the mismatch persists, the debounced level takes the synced value and the counter clears.
  - Press pulse: a register, high for exactly one cycle on the edge after the debounced level rises 0→1. Releases generate no pulse.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE: `count` = 0, prescaler = 0. `ss` press → RUN.
  - RUN: prescaler increments each cycle and wraps at TICK_DIV-1. On each wrap edge ("tick"), `count` increments. `ss` press → PAUSE.
  - PAUSE: prescaler and `count` hold, so a resume completes the partial period. `ss` press → RUN.
  - DONE: `count` = MAX_COUNT, prescaler holds. `ss` press is ignored.
  - Any state: `clr` press → IDLE with `count` = 0 and prescaler = 0.
- Saturation: a tick that makes `count` equal MAX_COUNT moves the state to RUN→DONE on that same edge. `count` never exceeds MAX_COUNT and never wraps.
- Simultaneous events on one edge:
  - `clr` and `ss` pulses: `clr` wins and the `ss` pulse is discarded.
  - `clr` pulse and tick: `clr` wins, so `count` = 0.
  - `ss` pulse and tick in RUN: the increment is applied and the state becomes PAUSE.
  - Tick reaching MAX_COUNT and `ss` pulse: the state becomes DONE.
- Holding a button generates one pulse only. A new pulse requires release (debounced 1→0) and a re-press.
- `rst` asserted mid-operation returns everything to reset values on the next edge, including partially counted debounce intervals.
- `count` is registered, and `running`/`done` decode the registered state, so all outputs are glitch-free and suitable for direct feed to the display stage.

## Timing
- Press latency, with edge 1 being the first edge sampling raw = 1 and the raw input held stable:
  - Synced high after edge 2.
  - Debounced level high after edge DEBOUNCE+2.
  - Press pulse high during the cycle after edge DEBOUNCE+3.
  - State, `running` and `done` update at edge DEBOUNCE+4.
- Bounce: any raw glitch shorter than DEBOUNCE cycles, after synchronisation, produces no level change.
- Count cadence in RUN from IDLE: the first increment lands at edge TICK_DIV after the RUN entry edge, with subsequent increments every TICK_DIV cycles.
- After PAUSE→RUN, the next increment lands at TICK_DIV minus the prescaler value held at pause.
- `count` changes at most once per TICK_DIV cycles and is stable between ticks.

## Test plan
Unless stated otherwise, use TICK_DIV=5, DEBOUNCE=4, MAX_COUNT=20.
- Reset/idle: assert `rst` for 3 cycles, hold buttons low for 50 cycles. `count`=0, `running`=0 and `done`=0 throughout.
- Start latency and cadence: raise `btn_ss` and hold it. `running` rises at edge 8. `count` = 1 at edge 13, 2 at edge 18, and stays 1 per 5 cycles thereafter. Holding the button produces no second toggle.
- Bounce rejection: toggle `btn_ss` with 1–3 cycle pulses for 40 cycles. No state change and no pulse. Then hold for 10 cycles: exactly one start.
- Pause/resume: pause when the prescaler holds 2, wait 30 cycles, then resume. `count` is frozen while paused, and the next increment lands 3 cycles after re-entering RUN.
- Saturation: run until `count` = 20. `done`=1 and `running`=0 on the same edge. Further `ss` presses leave `count`=20. A `clr` press yields `count`=0 and IDLE.
- Simultaneity and reset: press both buttons on the same cycle while running → IDLE, `count`=0. Assert `rst` mid-debounce and mid-run → all outputs 0 on the next edge, with no spurious pulse after release.
